// File: rtl/stk_pkg.sv
// Shared types for the stack-pointer controller: opcodes, engine ids, bank/line pointers, error causes.
// Pure declarations; no latency or backpressure of its own.
package stk_pkg;

  localparam int OPCODE_W = 2;
  localparam int ENGID_W  = 4;
  localparam int BANK_W   = 2;
  localparam int LINE_W   = 10;
  localparam int PTR_W    = BANK_W + LINE_W;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_INV  = 2'd3
  } opcode_t;

  typedef logic [ENGID_W-1:0] engid_t;
  typedef logic [BANK_W-1:0]  bank_id_t;
  typedef logic [LINE_W-1:0]  line_id_t;

  typedef struct packed {
    line_id_t line_id;
    bank_id_t bnk_id;
  } ptr_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_OVF    = 2'd1,
    ERR_UNF    = 2'd2,
    ERR_BADENG = 2'd3
  } err_cause_t;

  // Bank-interleaved: consecutive global entries land in consecutive banks.
  function automatic ptr_t g2ptr(input logic [PTR_W-1:0] g);
    ptr_t p;
    p.bnk_id  = g[BANK_W-1:0];
    p.line_id = g[PTR_W-1:BANK_W];
    return p;
  endfunction

endpackage

// File: rtl/stk_sp_cnt.sv
// Per-stack pointer: saturating up/down counter with clear and empty/full flags.
// Latency: new value one cycle after inc/dec/clr; flags are combinational from state.
// Backpressure: none; the caller only strobes when a command is accepted.
module stk_sp_cnt #(
  parameter int DEPTH = 512,
  parameter int SP_W  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  input  logic            i_dec,
  input  logic            i_clr,
  output logic [SP_W-1:0] o_sp,
  output logic            o_empty,
  output logic            o_full
);

  localparam logic [SP_W-1:0] FULL_V = SP_W'(DEPTH);

  logic [SP_W-1:0] r_sp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (i_clr) begin
      r_sp <= '0;
    end else if (i_inc && (r_sp != FULL_V)) begin
      r_sp <= r_sp + 1'b1;
    end else if (i_dec && (r_sp != '0)) begin
      r_sp <= r_sp - 1'b1;
    end
  end

  assign o_sp    = r_sp;
  assign o_empty = (r_sp == '0);
  assign o_full  = (r_sp == FULL_V);

endmodule

// File: rtl/stk_sp_ctrl.sv
// Multi-stack pointer controller: PUSH/POP/INV per engine, emitting the bank/line of the touched entry.
// Latency: response registered 1 cycle after acceptance; pointer updates in the acceptance cycle.
// Backpressure: single output register, in_rdy = !out_vld || out_rdy, so streaming runs without bubbles.
module stk_sp_ctrl
  import stk_pkg::*;
#(
  parameter int ENGS_N       = 8,
  parameter int BANKS_N      = 4,
  parameter int BANK_LINES_N = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  opcode_t           in_opcode,
  input  engid_t            in_engid,
  output logic              in_rdy,
  output logic              out_vld,
  output opcode_t           out_opcode,
  output engid_t            out_engid,
  output ptr_t              out_ptr,
  output logic              out_err,
  input  logic              out_rdy,
  output logic [ENGS_N-1:0] empty_w,
  output logic [ENGS_N-1:0] full_w
);

  localparam int DEPTH  = BANKS_N * BANK_LINES_N / ENGS_N;
  localparam int SP_W   = $clog2(DEPTH + 1);
  localparam int EIDX_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
  localparam logic [SP_W-1:0]  DEPTH_SP  = SP_W'(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

  logic [SP_W-1:0]   w_sp [ENGS_N];
  logic [ENGS_N-1:0] w_inc;
  logic [ENGS_N-1:0] w_dec;
  logic [ENGS_N-1:0] w_clr;
  logic              w_acc;
  logic              w_eng_ok;
  logic [EIDX_W-1:0] w_eid;
  logic [SP_W-1:0]   w_sp_sel;
  logic [PTR_W-1:0]  w_g;
  ptr_t              w_ptr;
  err_cause_t        w_cause;

  logic    r_vld;
  opcode_t r_opcode;
  engid_t  r_engid;
  ptr_t    r_ptr;
  logic    r_err;

  assign in_rdy   = !r_vld || out_rdy;
  assign w_acc    = in_vld && in_rdy;
  assign w_eng_ok = (int'(in_engid) < ENGS_N);
  assign w_eid    = in_engid[EIDX_W-1:0];
  assign w_sp_sel = w_sp[w_eid];

  // Strobes are gated by w_acc so the counters only move on an accepted command.
  always_comb begin
    w_cause = ERR_NONE;
    w_g     = '0;
    w_ptr   = '0;
    w_inc   = '0;
    w_dec   = '0;
    w_clr   = '0;
    if (!w_eng_ok) begin
      w_cause = ERR_BADENG;
    end else begin
      case (in_opcode)
        OP_PUSH: begin
          if (w_sp_sel == DEPTH_SP) begin
            w_cause = ERR_OVF;
          end else begin
            w_g          = PTR_W'(w_eid) * DEPTH_PTR + PTR_W'(w_sp_sel);
            w_ptr        = g2ptr(w_g);
            w_inc[w_eid] = w_acc;
          end
        end
        OP_POP: begin
          if (w_sp_sel == '0) begin
            w_cause = ERR_UNF;
          end else begin
            w_g          = PTR_W'(w_eid) * DEPTH_PTR + PTR_W'(w_sp_sel - 1'b1);
            w_ptr        = g2ptr(w_g);
            w_dec[w_eid] = w_acc;
          end
        end
        OP_INV:  w_clr[w_eid] = w_acc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld    <= 1'b0;
      r_opcode <= OP_NOP;
      r_engid  <= '0;
      r_ptr    <= '0;
      r_err    <= 1'b0;
    end else if (w_acc && (in_opcode != OP_NOP)) begin
      r_vld    <= 1'b1;
      r_opcode <= in_opcode;
      r_engid  <= in_engid;
      r_ptr    <= w_ptr;
      r_err    <= (w_cause != ERR_NONE);
    end else if (out_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign out_vld    = r_vld;
  assign out_opcode = r_opcode;
  assign out_engid  = r_engid;
  assign out_ptr    = r_ptr;
  assign out_err    = r_err;

  for (genvar e = 0; e < ENGS_N; e++) begin : g_cnt
    stk_sp_cnt #(
      .DEPTH (DEPTH),
      .SP_W  (SP_W)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_inc[e]),
      .i_dec   (w_dec[e]),
      .i_clr   (w_clr[e]),
      .o_sp    (w_sp[e]),
      .o_empty (empty_w[e]),
      .o_full  (full_w[e])
    );
  end

endmodule

// File: doc/stk_sp_ctrl.md
STK_SP_CTRL -- requirements
Module: stk_sp_ctrl

Interface
REQ-001 SHALL have parameter ENGS_N, default 8, number of independent stacks (power of two, at most 2**ENGID_W).
REQ-002 SHALL have parameter BANKS_N, default 4, storage banks (power of two).
REQ-003 SHALL have parameter BANK_LINES_N, default 1024, lines per bank (power of two).
REQ-004 SHALL use derived DEPTH = BANKS_N*BANK_LINES_N/ENGS_N, default 512, entries per stack.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_vld  in  1  command valid.
REQ-008 SHALL have port in_opcode  in  OPCODE_W  command opcode_t.
REQ-009 SHALL have port in_engid  in  ENGID_W  target stack.
REQ-010 SHALL have port in_rdy  out  1  command accepted when in_vld and in_rdy both high.
REQ-011 SHALL have port out_vld  out  1  storage-access/response valid.
REQ-012 SHALL have port out_opcode  out  OPCODE_W  echoed opcode.
REQ-013 SHALL have port out_engid  out  ENGID_W  echoed engine id.
REQ-014 SHALL have port out_ptr  out  PTR_W  ptr_t of accessed line.
REQ-015 SHALL have port out_err  out  1  overflow, underflow or bad engine id.
REQ-016 SHALL have port out_rdy  in  1  downstream accepts output.
REQ-017 SHALL have port empty_w  out  ENGS_N  per-stack empty flags.
REQ-018 SHALL have port full_w  out  ENGS_N  per-stack full flags.

Function
REQ-019 SHALL hold a per-stack pointer sp[e], range 0..DEPTH, width clog2(DEPTH+1).
REQ-020 SHALL drive in_rdy = !out_vld || out_rdy (single output register, no bubble under streaming).
REQ-021 SHALL register the response of an accepted command exactly 1 cycle after acceptance; out_* stay stable while out_vld && !out_rdy.
REQ-022 SHALL treat accepted NOP as consumed with no output and no state change.
REQ-023 SHALL on PUSH with sp[e] < DEPTH: out_ptr from g = e*DEPTH + sp[e], then sp[e] += 1, out_err=0.
REQ-024 SHALL on POP with sp[e] > 0: sp[e] -= 1, out_ptr from g = e*DEPTH + sp[e] - 1, out_err=0.
REQ-025 SHALL map g to ptr_t as bnk_id = g mod BANKS_N, line_id = g / BANKS_N (bank-interleaved).
REQ-026 SHALL on INV set sp[e] = 0, emit output with out_ptr=0, out_err=0.
REQ-027 SHALL on PUSH when full, POP when empty, or in_engid >= ENGS_N: emit output with out_err=1, out_ptr=0, no sp change.
REQ-028 SHALL update sp[e] in the acceptance cycle, so back-to-back commands to the same stack see the updated value (no hazard, no stall).
REQ-029 SHALL derive empty_w[e] = (sp[e]==0) and full_w[e] = (sp[e]==DEPTH) combinationally from state.
REQ-030 SHALL not accept a command while in_rdy is low; in_vld with in_rdy low leaves state unchanged.

Reset
REQ-031 SHALL on rst_n low at a clock edge set all sp to 0 and out_vld to 0; out_opcode/out_engid/out_ptr/out_err reset to 0.
REQ-032 SHALL reset after rst_n low: empty_w all ones, full_w all zeros, in_rdy 1.
REQ-033 SHALL discard an in-flight output and any command presented in the reset cycle.

Structure
REQ-034 SHALL take opcode_t, engid_t, ptr_t, bank_id_t, line_id_t, OPCODE_W, ENGID_W, PTR_W from stk_pkg.
REQ-035 SHALL have stk_pkg gain an error-cause enum (NONE, OVF, UNF, BADENG) for bench/debug; the port stays 1 bit.
REQ-036 SHALL implement per-stack pointer storage as sub-module stk_sp_cnt (up/down/clear counter with empty/full), instantiated ENGS_N times.
REQ-037 SHALL carry the global-index-to-ptr_t mapping in stk_pkg as a shared function.

Verification (defaults)
REQ-038 SHALL verify: reset, then PUSH eng 2 twice -> out_ptr {bnk 0, line 256} then {bnk 1, line 256}, err 0, empty_w[2]=0.
REQ-039 SHALL verify: POP eng 2 after the above -> out_ptr {bnk 1, line 256}; second POP -> {bnk 0, line 256}; third POP -> out_err=1, empty_w[2]=1.
REQ-040 SHALL verify: 512 PUSHes eng 7 -> last ptr {bnk 3, line 1023}, full_w[7]=1; 513th PUSH -> out_err=1, sp unchanged.
REQ-041 SHALL verify: out_rdy low 5 cycles with in_vld high -> in_rdy low, output stable, no command lost or duplicated.
REQ-042 SHALL verify: PUSH eng 0 three times, INV eng 0 -> err 0, empty_w[0]=1; next PUSH -> {bnk 0, line 0}.
REQ-043 SHALL verify: rst_n low mid-stream with out_vld high -> next cycle out_vld=0, all empty_w set.
